// File: rtl/multdiv_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
// The FSM encoding, iteration count and data width are defined only here.
package multdiv_pkg;

  localparam int XLEN       = 32;
  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = $clog2(ITER_COUNT);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_COUNT - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x);
    return x[XLEN-1] ? -x : x;
  endfunction

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter: 5-bit synchronous up-counter with clear, enable and
// a terminal-count flag marking the last iteration.
module multdiv_counter
  import multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clock) begin
    if (reset || clr) count <= '0;
    else if (en)      count <= count + CNT_W'(1);
  end

  assign tc = (count == CNT_LAST);

endmodule

// File: rtl/multdiv_core.sv
// Iterative signed multiply (radix-2 Booth) and divide (non-restoring on
// magnitudes), fixed 32-cycle latency, one-cycle data_resultRDY pulse.
module multdiv_core
  import multdiv_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] data_operandA,
  input  logic [XLEN-1:0] data_operandB,
  input  logic            ctrl_MULT,
  input  logic            ctrl_DIV,
  output logic [XLEN-1:0] data_result,
  output logic            data_exception,
  output logic            data_resultRDY,
  output logic            busy
);

  // Handshake: ctrl_MULT/ctrl_DIV are sampled every edge with no ready
  // back-pressure; any start restarts the unit, and data_resultRDY is a
  // single-cycle valid for data_result/data_exception, which then hold.
  state_t state, state_next;
  logic   start, iterating, last_iter;
  logic [CNT_W-1:0] count;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign iterating = (state == S_MULT) || (state == S_DIV);

  multdiv_counter u_counter (
    .clock (clock),
    .reset (reset),
    .clr   (start),
    .en    (iterating),
    .count (count),
    .tc    (last_iter)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (ctrl_MULT)     state_next = S_MULT;
    else if (ctrl_DIV) state_next = S_DIV;
    else begin
      case (state)
        S_MULT, S_DIV: if (last_iter) state_next = S_DONE;
        S_DONE:        state_next = S_IDLE;
        default:       state_next = state;
      endcase
    end
  end

  always_comb begin
    busy           = iterating;
    data_resultRDY = (state == S_DONE);
  end

  // Shared working registers: hi is the Booth accumulator or the partial
  // remainder (two guard bits keep both in range), lo is multiplier/quotient.
  logic [XLEN+1:0] hi, hi_n, sum, shifted, mcand, dsr;
  logic [XLEN-1:0] lo, lo_n, opnd;
  logic            qm1, qm1_n, neg_q, div_zero, div_ovf;

  assign mcand = {{2{opnd[XLEN-1]}}, opnd};
  assign dsr   = {2'b00, opnd};

  always_comb begin
    sum     = hi;
    shifted = '0;
    hi_n    = hi;
    lo_n    = lo;
    qm1_n   = qm1;
    if (state == S_DIV) begin
      shifted = {hi[XLEN:0], lo[XLEN-1]};
      hi_n    = hi[XLEN+1] ? shifted + dsr : shifted - dsr;
      lo_n    = {lo[XLEN-2:0], ~hi_n[XLEN+1]};
    end else begin
      case ({lo[0], qm1})
        2'b01:   sum = hi + mcand;
        2'b10:   sum = hi - mcand;
        default: sum = hi;
      endcase
      hi_n  = {sum[XLEN+1], sum[XLEN+1:1]};
      lo_n  = {sum[0], lo[XLEN-1:1]};
      qm1_n = lo[0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      qm1      <= 1'b0;
      opnd     <= '0;
      neg_q    <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
    end else if (start) begin
      hi  <= '0;
      qm1 <= 1'b0;
      if (ctrl_MULT) begin
        lo       <= data_operandB;
        opnd     <= data_operandA;
        neg_q    <= 1'b0;
        div_zero <= 1'b0;
        div_ovf  <= 1'b0;
      end else begin
        lo       <= abs_val(data_operandA);
        opnd     <= abs_val(data_operandB);
        neg_q    <= data_operandA[XLEN-1] ^ data_operandB[XLEN-1];
        div_zero <= (data_operandB == '0);
        div_ovf  <= (data_operandA == INT_MIN) && (data_operandB == '1);
      end
    end else if (iterating) begin
      hi  <= hi_n;
      lo  <= lo_n;
      qm1 <= qm1_n;
    end
  end

  // Final results are formed from the last iteration's next values so they
  // land in the output registers on the same edge that enters DONE.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   div_res;
  logic              mul_exc;

  assign prod    = {hi_n[XLEN-1:0], lo_n};
  assign mul_exc = ~((&prod[2*XLEN-1:XLEN-1]) | ~(|prod[2*XLEN-1:XLEN-1]));
  assign div_res = div_zero ? '0 : (neg_q ? -lo_n : lo_n);

  always_ff @(posedge clock) begin
    if (reset) begin
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (iterating && last_iter && !start) begin
      if (state == S_DIV) begin
        data_result    <= div_res;
        data_exception <= div_zero | div_ovf;
      end else begin
        data_result    <= lo_n;
        data_exception <= mul_exc;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_core.sv
// Self-checking bench for multdiv_core: directed vector table, hand-written
// abort/reset sequences, and randomized operations against an arithmetic model.
module tb_multdiv_core;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV  = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] exp_q[$];

  localparam int MODE_MULT = 0;
  localparam int MODE_DIV  = 1;
  localparam int MODE_BOTH = 2;
  localparam int LATENCY   = 33;

  typedef struct {
    int          mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[16];

  multdiv_core dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Results from the specification's arithmetic rules, not from the algorithm.
  function automatic logic [32:0] ref_model(input int mode, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     q;
    logic [63:0] pv;
    if (mode != MODE_DIV) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      pv = p;
      return {(p < -64'sd2147483648) || (p > 64'sd2147483647), pv[31:0]};
    end
    if (b == 32'd0) return {1'b1, 32'd0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    q = $signed(a) / $signed(b);
    return {1'b0, 32'(q)};
  endfunction

  // Called at a negedge; returns at the negedge following start edge E.
  task automatic pulse(input int mode, input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = (mode != MODE_DIV);
    ctrl_DIV  = (mode != MODE_MULT);
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  // Samples RDY for max negedges; k=1 is the negedge just after edge E.
  task automatic watch(input int max, output int n_rdy, output int first_k, output logic [32:0] got);
    n_rdy = 0;
    first_k = 0;
    got = '0;
    for (int k = 1; k <= max; k++) begin
      if (data_resultRDY) begin
        if (n_rdy == 0) begin
          first_k = k;
          got = {data_exception, data_result};
        end
        n_rdy++;
      end
      @(negedge clock);
    end
  endtask

  task automatic run_op(input int mode, input logic [31:0] a, input logic [31:0] b,
                        input logic [32:0] exp, input string name);
    int n_rdy, first_k;
    logic [32:0] got, e;
    exp_q.push_back(exp);
    pulse(mode, a, b);
    check({name, " busy"}, 64'(busy), 64'd1);
    watch(LATENCY + 3, n_rdy, first_k, got);
    e = exp_q.pop_front();
    check({name, " rdy_count"}, 64'(n_rdy), 64'd1);
    check({name, " latency"}, 64'(first_k), 64'(LATENCY));
    check({name, " result"}, 64'(got), 64'(e));
    check({name, " idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n_rdy, first_k, mode;
    logic [32:0] got;
    logic [31:0] a, b;
    logic [31:0] edge_vals[5];

    edge_vals[0] = 32'h0000_0000; edge_vals[1] = 32'h0000_0001;
    edge_vals[2] = 32'hFFFF_FFFF; edge_vals[3] = 32'h8000_0000;
    edge_vals[4] = 32'h7FFF_FFFF;

    vecs[0]  = '{MODE_MULT, 32'd7,          32'hFFFF_FFFD, {1'b0, 32'hFFFF_FFEB}, "mul_7x-3"};
    vecs[1]  = '{MODE_MULT, 32'h0001_0000,  32'h0001_0000, {1'b1, 32'h0000_0000}, "mul_ovf"};
    vecs[2]  = '{MODE_DIV,  32'hFFFF_FFF9,  32'd2,         {1'b0, 32'hFFFF_FFFD}, "div_-7/2"};
    vecs[3]  = '{MODE_DIV,  32'h8000_0000,  32'hFFFF_FFFF, {1'b1, 32'h8000_0000}, "div_min/-1"};
    vecs[4]  = '{MODE_DIV,  32'd5,          32'd0,         {1'b1, 32'h0000_0000}, "div_by_zero"};
    vecs[5]  = '{MODE_MULT, 32'd6,          32'd7,         {1'b0, 32'd42},        "mul_6x7"};
    vecs[6]  = '{MODE_DIV,  32'd100,        32'd7,         {1'b0, 32'd14},        "div_100/7"};
    vecs[7]  = '{MODE_MULT, 32'h8000_0000,  32'd1,         {1'b0, 32'h8000_0000}, "mul_min_x1"};
    vecs[8]  = '{MODE_MULT, 32'h8000_0000,  32'h8000_0000, {1'b1, 32'h0000_0000}, "mul_min_xmin"};
    vecs[9]  = '{MODE_MULT, 32'hFFFF_FFFF,  32'hFFFF_FFFF, {1'b0, 32'd1},         "mul_-1x-1"};
    vecs[10] = '{MODE_DIV,  32'd7,          32'hFFFF_FFFE, {1'b0, 32'hFFFF_FFFD}, "div_7/-2"};
    vecs[11] = '{MODE_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9, {1'b0, 32'd14},        "div_-100/-7"};
    vecs[12] = '{MODE_DIV,  32'h7FFF_FFFF,  32'h8000_0000, {1'b0, 32'd0},         "div_max/min"};
    vecs[13] = '{MODE_DIV,  32'h8000_0000,  32'h8000_0000, {1'b0, 32'd1},         "div_min/min"};
    vecs[14] = '{MODE_BOTH, 32'd6,          32'd3,         {1'b0, 32'd18},        "both_mult_wins"};
    vecs[15] = '{MODE_MULT, 32'hFFFF_0000,  32'h0000_8000, {1'b0, 32'h8000_0000}, "mul_neg_edge"};

    // Reset state
    repeat (3) @(negedge clock);
    check("reset_result", 64'(data_result), 64'd0);
    check("reset_exc",    64'(data_exception), 64'd0);
    check("reset_rdy",    64'(data_resultRDY), 64'd0);
    check("reset_busy",   64'(busy), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    foreach (vecs[i]) run_op(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

    // Restart mid-flight: MULT at E, DIV at E+10; only the DIV completes.
    pulse(MODE_MULT, 32'd3, 32'd4);
    repeat (9) @(negedge clock);
    run_op(MODE_DIV, 32'd100, 32'd7, {1'b0, 32'd14}, "abort_div");

    // Reset at edge E+15 of a MULT discards it.
    pulse(MODE_MULT, 32'd9, 32'd9);
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midreset_result", 64'(data_result), 64'd0);
    check("midreset_exc",    64'(data_exception), 64'd0);
    check("midreset_rdy",    64'(data_resultRDY), 64'd0);
    check("midreset_busy",   64'(busy), 64'd0);
    watch(40, n_rdy, first_k, got);
    check("midreset_no_rdy", 64'(n_rdy), 64'd0);
    run_op(MODE_MULT, 32'd6, 32'd7, {1'b0, 32'd42}, "after_reset_mul");

    // Reset beats a simultaneous start.
    data_operandA = 32'd6;
    data_operandB = 32'd7;
    ctrl_MULT = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    reset = 1'b0;
    check("rst_prio_busy", 64'(busy), 64'd0);
    watch(40, n_rdy, first_k, got);
    check("rst_prio_no_rdy", 64'(n_rdy), 64'd0);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0:       a = 32'($urandom_range(0, 40)) - 32'd20;
        1:       a = edge_vals[$urandom_range(0, 4)];
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       b = 32'($urandom_range(0, 40)) - 32'd20;
        1:       b = edge_vals[$urandom_range(0, 4)];
        2:       b = 32'($urandom_range(0, 1000));
        default: b = $urandom;
      endcase
      run_op(mode, a, b, ref_model(mode, a, b), $sformatf("rand%0d", i));
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
